// File: rtl/bsg_manycore_vcache_wh_mem_responder_pkg.sv
// Shared types for the vcache DMA wormhole memory responder: header flit layout and FSM states.
// Header fields are declared MSB-first so that cord lands at bit 0 of the flit.
`define BSG_MANYCORE_VCACHE_WH_HEADER_S(cord_w, len_w, cid_w) \
  typedef struct packed {                                       \
    logic              write_not_read;                          \
    logic [cid_w-1:0]  src_cid;                                 \
    logic [cord_w-1:0] src_cord;                                \
    logic [cid_w-1:0]  cid;                                     \
    logic [len_w-1:0]  len;                                     \
    logic [cord_w-1:0] cord;                                    \
  } wh_hdr_s

package bsg_manycore_vcache_wh_mem_responder_pkg;

  typedef enum logic [2:0] {IDLE, ADDR, WR_DATA, RD_HDR, RD_DATA} wh_resp_state_e;

  localparam logic [1:0] read_credits_lp = 2'd2;

  function automatic int unsigned max_width(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bsg_manycore_vcache_wh_mem_responder_fifo.sv
// Two-entry ready/valid FIFO with asynchronous reset; holds read data returning to the link.
module bsg_manycore_vcache_wh_mem_responder_fifo #(
  parameter int width_p = 32
) (
  input  logic               clk_i,
  input  logic               reset_i,
  output logic               ready_o,
  input  logic [width_p-1:0] data_i,
  input  logic               v_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  logic [width_p-1:0] r_mem [2];
  logic               r_head;
  logic [1:0]         r_cnt;
  logic               w_enq;
  logic               w_wr_idx;

  assign ready_o  = (r_cnt != 2'd2);
  assign v_o      = (r_cnt != 2'd0);
  assign data_o   = r_mem[r_head];
  assign w_enq    = v_i & ready_o;
  assign w_wr_idx = r_head ^ r_cnt[0];

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_head   <= 1'b0;
      r_cnt    <= 2'd0;
    end else begin
      if (w_enq) r_mem[w_wr_idx] <= data_i;
      if (yumi_i) r_head <= ~r_head;
      r_cnt <= r_cnt + {1'b0, w_enq} - {1'b0, yumi_i};
    end
  end

endmodule

// File: rtl/bsg_manycore_vcache_wh_mem_responder.sv
// Far-end wormhole responder: executes vcache DMA read/write bursts against a ready/valid word memory
// and returns read data as wormhole packets addressed to the requesting tile.
module bsg_manycore_vcache_wh_mem_responder
  import bsg_manycore_vcache_wh_mem_responder_pkg::*;
#(
  parameter int wh_flit_width_p  = 32,
  parameter int wh_cord_width_p  = 16,
  parameter int wh_len_width_p   = 4,
  parameter int wh_cid_width_p   = 2,
  parameter int dma_addr_width_p = 28,
  parameter int dma_burst_len_p  = 8
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic [wh_flit_width_p+1:0]  wh_link_sif_i,
  output logic [wh_flit_width_p+1:0]  wh_link_sif_o,
  output logic                        mem_v_o,
  output logic                        mem_w_o,
  output logic [dma_addr_width_p-1:0] mem_addr_o,
  output logic [wh_flit_width_p-1:0]  mem_data_o,
  input  logic                        mem_ready_and_i,
  input  logic                        mem_v_i,
  input  logic [wh_flit_width_p-1:0]  mem_data_i,
  output logic                        mem_yumi_o
);

  `BSG_MANYCORE_VCACHE_WH_HEADER_S(wh_cord_width_p, wh_len_width_p, wh_cid_width_p);

  // Header fields beyond the flit width are zero on input and dropped on output.
  localparam int unsigned HDR_W = $bits(wh_hdr_s);
  localparam int unsigned EXT_W = max_width(HDR_W, wh_flit_width_p);
  localparam int unsigned CNT_W = $clog2(dma_burst_len_p + 1);
  localparam logic [CNT_W-1:0] BURST     = CNT_W'(dma_burst_len_p);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(dma_burst_len_p - 1);
  localparam logic [dma_addr_width_p-1:0] BYTES = dma_addr_width_p'(wh_flit_width_p / 8);

  wh_resp_state_e              r_state;
  logic [wh_cord_width_p-1:0]  r_src_cord;
  logic [wh_cid_width_p-1:0]   r_src_cid;
  logic                        r_wnr;
  logic [dma_addr_width_p-1:0] r_addr;
  logic [CNT_W-1:0]            r_beat;
  logic [CNT_W-1:0]            r_send;
  logic [1:0]                  r_credits;

  logic                       w_in_v, w_out_ready, w_req_ready, w_in_fire;
  logic [wh_flit_width_p-1:0] w_in_data, w_out_data, w_fifo_data, w_rsp_flit;
  logic [EXT_W-1:0]           w_in_ext, w_rsp_ext;
  wh_hdr_s                    w_in_hdr, w_rsp_hdr;
  logic                       w_issue, w_mem_fire, w_fifo_v, w_fifo_ready, w_deq, w_out_v;
  logic                       w_unused;

  assign w_in_v      = wh_link_sif_i[wh_flit_width_p+1];
  assign w_out_ready = wh_link_sif_i[wh_flit_width_p];
  assign w_in_data   = wh_link_sif_i[wh_flit_width_p-1:0];

  always_comb begin
    w_in_ext = '0;
    w_in_ext[wh_flit_width_p-1:0] = w_in_data;
    w_in_hdr = wh_hdr_s'(w_in_ext[HDR_W-1:0]);
    w_rsp_hdr      = '0;
    w_rsp_hdr.cord = r_src_cord;
    w_rsp_hdr.cid  = r_src_cid;
    w_rsp_hdr.len  = wh_len_width_p'(dma_burst_len_p);
    w_rsp_ext = '0;
    w_rsp_ext[HDR_W-1:0] = w_rsp_hdr;
    w_rsp_flit = w_rsp_ext[wh_flit_width_p-1:0];
  end

  assign w_unused = ^{w_in_ext, w_in_hdr, w_rsp_ext};

  always_comb begin
    w_req_ready = 1'b0;
    if (!reset_i) begin
      case (r_state)
        IDLE, ADDR: w_req_ready = 1'b1;
        WR_DATA:    w_req_ready = mem_ready_and_i;
        default:    w_req_ready = 1'b0;
      endcase
    end
  end

  assign w_in_fire  = w_in_v & w_req_ready;
  assign w_issue    = (r_state == RD_DATA) && (r_beat != BURST) && (r_credits != 2'd0);
  assign mem_v_o    = (r_state == WR_DATA) ? w_in_v : w_issue;
  assign mem_w_o    = (r_state == WR_DATA);
  assign mem_addr_o = r_addr + dma_addr_width_p'(r_beat) * BYTES;
  assign mem_data_o = (r_state == WR_DATA) ? w_in_data : '0;
  assign w_mem_fire = mem_v_o & mem_ready_and_i;
  assign mem_yumi_o = mem_v_i & w_fifo_ready;
  assign w_deq      = (r_state == RD_DATA) & w_fifo_v & w_out_ready;
  assign w_out_v    = (r_state == RD_HDR) | ((r_state == RD_DATA) & w_fifo_v);
  assign w_out_data = (r_state == RD_HDR)  ? w_rsp_flit :
                      (r_state == RD_DATA) ? w_fifo_data : '0;
  assign wh_link_sif_o = {w_out_v, w_req_ready, w_out_data};

  bsg_manycore_vcache_wh_mem_responder_fifo #(
    .width_p(wh_flit_width_p)
  ) u_ret_fifo (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .ready_o(w_fifo_ready),
    .data_i (mem_data_i),
    .v_i    (mem_v_i),
    .v_o    (w_fifo_v),
    .data_o (w_fifo_data),
    .yumi_i (w_deq)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state    <= IDLE;
      r_src_cord <= '0;
      r_src_cid  <= '0;
      r_wnr      <= 1'b0;
      r_addr     <= '0;
      r_beat     <= '0;
      r_send     <= '0;
      r_credits  <= 2'd0;
    end else begin
      case (r_state)
        IDLE: if (w_in_fire) begin
          r_src_cord <= w_in_hdr.src_cord;
          r_src_cid  <= w_in_hdr.src_cid;
          r_wnr      <= w_in_hdr.write_not_read;
          r_state    <= ADDR;
        end
        ADDR: if (w_in_fire) begin
          r_addr  <= w_in_data[dma_addr_width_p-1:0];
          r_beat  <= '0;
          r_state <= r_wnr ? WR_DATA : RD_HDR;
        end
        WR_DATA: if (w_mem_fire) begin
          r_beat <= r_beat + 1'b1;
          if (r_beat == LAST_BEAT) r_state <= IDLE;
        end
        RD_HDR: if (w_out_ready) begin
          r_beat    <= '0;
          r_send    <= '0;
          r_credits <= read_credits_lp;
          r_state   <= RD_DATA;
        end
        RD_DATA: begin
          // r_beat doubles as the read issue count here
          if (w_mem_fire) r_beat <= r_beat + 1'b1;
          r_credits <= r_credits + {1'b0, w_deq} - {1'b0, w_mem_fire};
          if (w_deq) begin
            r_send <= r_send + 1'b1;
            if (r_send == LAST_BEAT) r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bsg_manycore_vcache_wh_mem_responder.sv
// Randomized bench for the wormhole memory responder: a memory model plus a packet-level
// reference that predicts memory writes, read addresses and response flits.
module tb_bsg_manycore_vcache_wh_mem_responder;

  localparam int W = 32, A = 28, B = 8, TMO = 3000;

  logic          clk = 1'b0, rst = 1'b0;
  logic          in_v = 1'b0, rsp_rdy = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic [W+1:0]  link_i, link_o;
  logic          mem_v_o, mem_w_o, mem_ready = 1'b0, mem_v_i = 1'b0, mem_yumi;
  logic [A-1:0]  mem_addr;
  logic [W-1:0]  mem_data_o, mem_data_i = '0;
  logic          out_v, req_rdy;
  logic [W-1:0]  out_data;

  assign link_i   = {in_v, rsp_rdy, in_data};
  assign out_v    = link_o[W+1];
  assign req_rdy  = link_o[W];
  assign out_data = link_o[W-1:0];

  always #5 clk = ~clk;

  bsg_manycore_vcache_wh_mem_responder #(
    .wh_flit_width_p(W), .wh_cord_width_p(8), .wh_len_width_p(4),
    .wh_cid_width_p(2), .dma_addr_width_p(A), .dma_burst_len_p(B)
  ) dut (
    .clk_i(clk), .reset_i(rst), .wh_link_sif_i(link_i), .wh_link_sif_o(link_o),
    .mem_v_o(mem_v_o), .mem_w_o(mem_w_o), .mem_addr_o(mem_addr), .mem_data_o(mem_data_o),
    .mem_ready_and_i(mem_ready), .mem_v_i(mem_v_i), .mem_data_i(mem_data_i), .mem_yumi_o(mem_yumi)
  );

  int checks = 0, failures = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [W-1:0] ref_mem [logic [A-1:0]];
  logic [W-1:0] dev_mem [logic [A-1:0]];
  logic [63:0]  exp_wr[$];
  logic [A-1:0] exp_rd_addr[$];
  logic [W-1:0] exp_rsp[$];
  logic [W-1:0] ret_data[$];
  int           ret_due[$];
  int cyc = 0, last_due = 0, bp_hold = 0, rd_issued = 0, rsp_cnt = 0, rsp_data_sent = 0;
  bit mem_rdy_rand = 0, rsp_rdy_rand = 0, gap_en = 0, in_wr_data = 0;

  function automatic logic [W-1:0] rd_ref(input logic [A-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : '0;
  endfunction

  function automatic logic [W-1:0] rd_dev(input logic [A-1:0] a);
    return dev_mem.exists(a) ? dev_mem[a] : '0;
  endfunction

  function automatic logic [W-1:0] req_hdr(input int sc, input int sid, input int wnr);
    return W'(7 + (1 << 8) + (1 << 12) + (sc << 14) + (sid << 22) + (wnr << 24));
  endfunction

  function automatic logic [W-1:0] rsp_hdr(input int sc, input int sid);
    return W'(sc + (B << 8) + (sid << 12));
  endfunction

  task automatic preload(input logic [A-1:0] a, input logic [W-1:0] d);
    ref_mem[a] = d;
    dev_mem[a] = d;
  endtask

  task automatic monitor();
    logic rf, mf, of;
    int due;
    rf = in_v & req_rdy;
    mf = mem_v_o & mem_ready;
    of = out_v & rsp_rdy;
    if (exp_rsp.size() != 0) chk("req_blocked", 64'(req_rdy), 64'd0);
    if (in_wr_data) chk("wr_flit_with_mem", 64'(rf), 64'(mf & mem_w_o));
    if (of) begin
      if (exp_rsp.size() == 0) chk("unexp_rsp", 64'(out_data), 64'hDEAD);
      else chk("rsp_flit", 64'(out_data), 64'(exp_rsp.pop_front()));
      if (rsp_cnt > 0) rsp_data_sent++;
      rsp_cnt++;
    end
    if (mf && mem_w_o) begin
      if (exp_wr.size() == 0) chk("unexp_wr", {4'h0, mem_addr, mem_data_o}, 64'hDEAD);
      else chk("wr_cmd", {4'h0, mem_addr, mem_data_o}, exp_wr.pop_front());
      dev_mem[mem_addr] = mem_data_o;
    end else if (mf) begin
      if (exp_rd_addr.size() == 0) chk("unexp_rd", 64'(mem_addr), 64'hDEAD);
      else chk("rd_addr", 64'(mem_addr), 64'(exp_rd_addr.pop_front()));
      rd_issued++;
      chk("outstanding_le2", 64'((rd_issued - rsp_data_sent) <= 2), 64'd1);
      due = cyc + 1 + int'($urandom_range(0, 3));
      if (due < last_due) due = last_due;
      last_due = due;
      ret_data.push_back(rd_dev(mem_addr));
      ret_due.push_back(due);
    end
    if (mem_v_i && mem_yumi && ret_data.size() != 0) begin
      void'(ret_data.pop_front());
      void'(ret_due.pop_front());
    end
  endtask

  task automatic drive_env();
    if (rst) begin
      ret_data.delete(); ret_due.delete();
      mem_v_i = 1'b0; mem_ready = 1'b0; rsp_rdy = 1'b0;
      return;
    end
    mem_ready = mem_rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    if (bp_hold > 0) begin
      rsp_rdy = 1'b0;
      bp_hold--;
    end else rsp_rdy = rsp_rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    if (ret_data.size() != 0 && ret_due[0] <= cyc && $urandom_range(0, 4) != 0) begin
      mem_v_i = 1'b1; mem_data_i = ret_data[0];
    end else begin
      mem_v_i = 1'b0; mem_data_i = '0;
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) monitor();
      @(posedge clk); #1;
      drive_env();
    end
  end

  task automatic send_flit(input logic [W-1:0] d);
    logic f;
    if (gap_en && $urandom_range(0, 2) == 0) begin @(posedge clk); #1; end
    in_v = 1'b1; in_data = d;
    for (int n = 0; ; n++) begin
      @(negedge clk); f = req_rdy;
      @(posedge clk); #1;
      if (f) break;
      if (n == TMO) begin chk("flit_timeout", 64'd0, 64'd1); break; end
    end
    in_v = 1'b0; in_data = '0;
  endtask

  task automatic do_write(input int sc, input int sid, input logic [A-1:0] a, input logic [W-1:0] d [B]);
    logic [A-1:0] wa;
    for (int i = 0; i < B; i++) begin
      wa = a + A'(4 * i);
      exp_wr.push_back({4'h0, wa, d[i]});
      ref_mem[wa] = d[i];
    end
    send_flit(req_hdr(sc, sid, 1));
    send_flit(W'(a));
    in_wr_data = 1;
    for (int i = 0; i < B; i++) send_flit(d[i]);
    in_wr_data = 0;
    chk("wr_drained", 64'(exp_wr.size()), 64'd0);
  endtask

  task automatic start_read(input int sc, input int sid, input logic [A-1:0] a);
    send_flit(req_hdr(sc, sid, 0));
    send_flit(W'(a));
    rd_issued = 0; rsp_cnt = 0; rsp_data_sent = 0;
    exp_rsp.push_back(rsp_hdr(sc, sid));
    for (int i = 0; i < B; i++) begin
      exp_rd_addr.push_back(a + A'(4 * i));
      exp_rsp.push_back(rd_ref(a + A'(4 * i)));
    end
  endtask

  task automatic wait_rsp_done();
    for (int n = 0; n < TMO && exp_rsp.size() != 0; n++) begin @(posedge clk); #1; end
    chk("rsp_done", 64'(exp_rsp.size()), 64'd0);
    chk("rd_addr_drained", 64'(exp_rd_addr.size()), 64'd0);
  endtask

  task automatic wait_sent(input int k);
    for (int n = 0; n < TMO && rsp_data_sent < k; n++) begin @(posedge clk); #1; end
    chk("sent_reached", 64'(rsp_data_sent >= k), 64'd1);
  endtask

  task automatic apply_reset();
    rst = 1'b1; in_v = 1'b0; in_wr_data = 0; bp_hold = 0;
    #1;
    chk("rst_out_v", 64'(out_v), 64'd0);
    chk("rst_req_rdy", 64'(req_rdy), 64'd0);
    chk("rst_mem_v", 64'(mem_v_o), 64'd0);
    exp_wr.delete(); exp_rd_addr.delete(); exp_rsp.delete();
    ret_data.delete(); ret_due.delete();
    repeat (3) @(posedge clk);
    #1; rst = 1'b0;
    #1;
    chk("idle_ready", 64'(req_rdy), 64'd1);
    chk("idle_out_v", 64'(out_v), 64'd0);
  endtask

  logic [W-1:0] d [B];

  initial begin
    #3 rst = 1'b1;
    @(posedge clk); #1;
    apply_reset();

    for (int i = 0; i < B; i++) d[i] = W'(i + 1);
    do_write(5, 2, 28'h100, d);

    for (int i = 0; i < B; i++) preload(28'h200 + A'(4 * i), 32'hA0 + W'(i));
    start_read(3, 1, 28'h200);
    wait_rsp_done();

    start_read(7, 3, 28'h200);
    wait_sent(2);
    bp_hold = 10;
    wait_rsp_done();

    mem_rdy_rand = 1;
    for (int i = 0; i < B; i++) d[i] = $urandom;
    do_write(1, 0, 28'h340, d);
    mem_rdy_rand = 0;

    rsp_rdy_rand = 1;
    start_read(2, 1, 28'h100);
    for (int i = 0; i < B; i++) d[i] = $urandom;
    do_write(4, 2, 28'h400, d);
    wait_rsp_done();
    rsp_rdy_rand = 0;

    start_read(6, 0, 28'h200);
    wait_sent(3);
    apply_reset();
    start_read(3, 1, 28'h200);
    wait_rsp_done();

    for (int i = 0; i < 4; i++) begin
      preload(28'hFFFFFF0 + A'(4 * i), $urandom);
      preload(28'h0000000 + A'(4 * i), $urandom);
    end
    start_read(9, 2, 28'hFFFFFF0);
    wait_rsp_done();
    for (int i = 0; i < B; i++) d[i] = $urandom;
    do_write(8, 1, 28'hFFFFFF8, d);

    for (int it = 0; it < 16; it++) begin
      logic [A-1:0] a;
      a = 28'h800 + A'($urandom_range(0, 63) * 4);
      mem_rdy_rand = 1'($urandom_range(0, 1));
      rsp_rdy_rand = 1'($urandom_range(0, 1));
      gap_en       = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < B; i++) d[i] = $urandom;
        do_write(int'($urandom_range(0, 255)), int'($urandom_range(0, 3)), a, d);
      end else begin
        start_read(int'($urandom_range(0, 255)), int'($urandom_range(0, 3)), a);
        if ($urandom_range(0, 2) == 0) begin
          wait_sent(1);
          bp_hold = int'($urandom_range(3, 12));
        end
        wait_rsp_done();
      end
    end

    repeat (5) @(posedge clk);
    chk("final_wr_empty", 64'(exp_wr.size()), 64'd0);
    chk("final_rsp_empty", 64'(exp_rsp.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
